// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter with bounded burst lock sharing one fifo write port
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req_valid_i     per-requester beat available
//   req_data_i      per-requester payload, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o     per-requester accept, at most one bit high
//   fifo_nfull_i    fifo can take a beat
//   fifo_wr_en_o    fifo write strobe
//   fifo_wr_data_o  {source id, payload}
//   grant_active_o  a burst lock is held
//   grant_id_o      current or last owner index
module fifo_wr_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  fifo_nfull_i,
    output logic                  fifo_wr_en_o,
    output logic [IDW+WIDTH-1:0]  fifo_wr_data_o,
    output logic                  grant_active_o,
    output logic [IDW-1:0]        grant_id_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d, rr_q, rr_d, sel, pick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic any, lock, go;
    function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ - 1)) ? '0 : x + IDW'(1);
    endfunction
    // Scan from the highest offset down so the last hit is the closest to rr_q.
    always_comb begin
        sel = rr_q;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[(int'(rr_q) + k) % NREQ]) begin
                sel = IDW'((int'(rr_q) + k) % NREQ);
                any = 1'b1;
            end
        end
    end
    assign lock = (state_q == LOCKED);
    assign pick = lock ? owner_q : sel;
    assign go = fifo_nfull_i & (lock ? req_valid_i[owner_q] : any);
    // In a lock the owner's ready follows nfull alone, independent of its own valid.
    always_comb begin
        req_ready_o = '0;
        if (!rst && (lock || any) && fifo_nfull_i) req_ready_o[pick] = 1'b1;
    end
    assign fifo_wr_en_o = !rst && go;
    assign fifo_wr_data_o = fifo_wr_en_o ? {pick, req_data_i[pick*WIDTH +: WIDTH]} : '0;
    assign grant_active_o = lock;
    assign grant_id_o = fifo_wr_en_o ? pick : owner_q;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        cnt_d = cnt_q;
        if (!lock) begin
            if (go) begin
                owner_d = sel;
                if (MAX_BURST == 1) rr_d = nxt(sel);
                else begin
                    state_d = LOCKED;
                    cnt_d = CW'(1);
                end
            end
        end else if (!req_valid_i[owner_q] || (fifo_nfull_i && cnt_q + CW'(1) == CW'(MAX_BURST))) begin
            state_d = IDLE;
            rr_d = nxt(owner_q);
            cnt_d = '0;
        end else if (fifo_nfull_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of burst-locked and per-beat round-robin arbitration
module tb_fifo_wr_arbiter;
    logic clk = 1'b0, rst = 1'b1, nfull = 1'b1;
    logic [3:0] v0 = '0, v1 = '0, r0, r1;
    logic [63:0] data = 64'hD003_D002_D001_D000;
    logic we0, we1, ga0, ga1;
    logic [17:0] wd0, wd1;
    logic [1:0] gi0, gi1;
    int n_chk = 0, n_fail = 0;
    fifo_wr_arbiter #(.WIDTH(16), .NREQ(4), .MAX_BURST(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid_i(v0), .req_data_i(data), .req_ready_o(r0),
        .fifo_nfull_i(nfull), .fifo_wr_en_o(we0), .fifo_wr_data_o(wd0),
        .grant_active_o(ga0), .grant_id_o(gi0));
    fifo_wr_arbiter #(.WIDTH(16), .NREQ(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid_i(v1), .req_data_i(data), .req_ready_o(r1),
        .fifo_nfull_i(nfull), .fifo_wr_en_o(we1), .fifo_wr_data_o(wd1),
        .grant_active_o(ga1), .grant_id_o(gi1));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] word(input int id);
        return 32'((id << 16) | (16'hD000 + id));
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic beat0(input string tag, input int id, input logic act);
        @(negedge clk);
        check({tag, ".wr_en"}, 32'(we0), 32'd1);
        check({tag, ".data"}, 32'(wd0), word(id));
        check({tag, ".ready"}, 32'(r0), 32'(1 << id));
        check({tag, ".gid"}, 32'(gi0), 32'(id));
        check({tag, ".active"}, 32'(ga0), 32'(act));
        tick();
    endtask
    task automatic bubble0(input string tag, input logic act, input int gid, input logic [3:0] rdy);
        @(negedge clk);
        check({tag, ".wr_en"}, 32'(we0), 32'd0);
        check({tag, ".data"}, 32'(wd0), 32'd0);
        check({tag, ".ready"}, 32'(r0), 32'(rdy));
        check({tag, ".gid"}, 32'(gi0), 32'(gid));
        check({tag, ".active"}, 32'(ga0), 32'(act));
        tick();
    endtask
    task automatic beat1(input string tag, input int id);
        @(negedge clk);
        check({tag, ".wr_en"}, 32'(we1), 32'd1);
        check({tag, ".data"}, 32'(wd1), word(id));
        check({tag, ".ready"}, 32'(r1), 32'(1 << id));
        check({tag, ".gid"}, 32'(gi1), 32'(id));
        check({tag, ".active"}, 32'(ga1), 32'd0);
        tick();
    endtask
    initial begin
        v0 = 4'hF;
        v1 = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst.ready0", 32'(r0), 32'd0);
            check("rst.wr_en0", 32'(we0), 32'd0);
            check("rst.ready1", 32'(r1), 32'd0);
            check("rst.wr_en1", 32'(we1), 32'd0);
            tick();
        end
        rst = 1'b0;
        v1 = 4'h0;
        for (int k = 0; k < 17; k++) beat0("burst", (k / 4) % 4, (k % 4) != 0);
        rst = 1'b1;
        v0 = 4'b0100;
        tick();
        rst = 1'b0;
        beat0("drop", 2, 1'b0);
        beat0("drop", 2, 1'b1);
        v0 = 4'b1011;
        bubble0("drop_bubble", 1'b1, 2, 4'b0100);
        beat0("after_drop", 3, 1'b0);
        for (int k = 0; k < 3; k++) beat0("after_drop", 3, 1'b1);
        beat0("next_owner", 0, 1'b0);
        beat0("next_owner", 0, 1'b1);
        nfull = 1'b0;
        for (int k = 0; k < 5; k++) bubble0("stall", 1'b1, 0, 4'b0000);
        nfull = 1'b1;
        beat0("resume", 0, 1'b1);
        beat0("resume", 0, 1'b1);
        beat0("rotate", 1, 1'b0);
        rst = 1'b1;
        v0 = 4'b1000;
        tick();
        rst = 1'b0;
        beat0("pre_rst", 3, 1'b0);
        beat0("pre_rst", 3, 1'b1);
        v0 = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst.ready", 32'(r0), 32'd0);
        check("mid_rst.wr_en", 32'(we0), 32'd0);
        tick();
        rst = 1'b0;
        beat0("post_rst", 0, 1'b0);
        v0 = 4'h0;
        bubble0("owner_gone", 1'b1, 0, 4'b0001);
        bubble0("no_valid", 1'b0, 0, 4'b0000);
        v1 = 4'b1010;
        for (int k = 0; k < 6; k++) beat1("rr1", (k % 2 == 0) ? 1 : 3);
        nfull = 1'b0;
        @(negedge clk);
        check("rr1_full.wr_en", 32'(we1), 32'd0);
        check("rr1_full.ready", 32'(r1), 32'd0);
        tick();
        nfull = 1'b1;
        beat1("rr1_resume", 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
